// File: rtl/port_fifo_if.sv
// port_fifo_if: producer/consumer handshake bundle for port_fifo.
// slave = queue side, master = driving environment side.
interface port_fifo_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
);
  logic                     push_valid;
  logic [WIDTH-1:0]         push_data;
  logic                     push_ready;
  logic                     flush;
  logic                     pop_valid;
  logic [WIDTH-1:0]         pop_data;
  logic                     pop_ready;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  push_valid, push_data, flush, pop_ready,
    output push_ready, pop_valid, pop_data, count
  );

  modport master (
    output push_valid, push_data, flush, pop_ready,
    input  push_ready, pop_valid, pop_data, count
  );
endinterface

// File: rtl/port_fifo.sv
// port_fifo: elastic stage port, DEPTH-entry first-word-fall-through queue.
// All outputs come from registered state; flush/rst empty it in one cycle.
module port_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  port_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_fire;
  logic             pop_fire;
  logic             clr;

  assign clr       = rst | bus.flush;
  assign push_fire = bus.push_valid & bus.push_ready;
  assign pop_fire  = bus.pop_valid & bus.pop_ready;

  assign bus.push_ready = (cnt != FULL);
  assign bus.pop_valid  = (cnt != '0);
  assign bus.pop_data   = bus.pop_valid ? mem[rd_ptr] : '0;
  assign bus.count      = cnt;

  // Pointer and occupancy update; clear beats any transfer.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push_fire && !pop_fire: cnt <= cnt + 1'b1;
        pop_fire && !push_fire: cnt <= cnt - 1'b1;
        default:                cnt <= cnt;
      endcase
    end
  end

  // Payload storage, no reset; suppressed when clearing.
  always_ff @(posedge clk) begin
    if (!clr && push_fire) mem[wr_ptr] <= bus.push_data;
  end
endmodule

// File: tb/tb_port_fifo.sv
// tb_port_fifo: directed + random stimulus against a queue model.
// Monitor compares DUT outputs with the model every cycle.
module tb_port_fifo;
  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   armed = 1'b0;
  logic [W-1:0] q[$];

  port_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  port_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare against model, then advance model over next edge.
  always @(negedge clk) begin
    int sz;
    logic [W-1:0] e;
    if (rst) begin
      armed = 1'b1;
      q.delete();
    end else if (armed) begin
      sz = q.size();
      e  = (sz != 0) ? q[0] : '0;
      chk("count", int'(bus.count), sz);
      chk("push_ready", int'(bus.push_ready), int'(sz != D));
      chk("pop_valid", int'(bus.pop_valid), int'(sz != 0));
      chk("pop_data", int'(bus.pop_data), int'(e));
      if (bus.flush) begin
        q.delete();
      end else begin
        if (bus.pop_ready && sz != 0) void'(q.pop_front());
        if (bus.push_valid && sz != D) q.push_back(bus.push_data);
      end
    end
  end

  task automatic drv(input bit r, input bit fl, input bit pv,
                     input logic [W-1:0] pd, input bit pr);
    @(posedge clk);
    #1;
    rst            = r;
    bus.flush      = fl;
    bus.push_valid = pv;
    bus.push_data  = pd;
    bus.pop_ready  = pr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 8'h00, 0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 8'h00, 1);
  endtask

  initial begin
    bus.flush      = 1'b0;
    bus.push_valid = 1'b0;
    bus.push_data  = '0;
    bus.pop_ready  = 1'b0;
    // 1: reset, single push, fall-through visible next cycle
    drv(1, 0, 0, 8'h00, 0);
    drv(0, 0, 1, 8'hA5, 0);
    idle(2);
    drain(2);
    // 2: fill to full, held 5th push, drain in order
    for (int i = 1; i <= 4; i++) drv(0, 0, 1, W'(i), 0);
    drv(0, 0, 1, 8'h05, 0);
    drv(0, 0, 1, 8'h05, 1);
    drv(0, 0, 0, 8'h00, 0);
    drain(6);
    // 3: simultaneous push and pop at count 2
    drv(0, 0, 1, 8'h21, 0);
    drv(0, 0, 1, 8'h22, 0);
    drv(0, 0, 1, 8'h23, 1);
    drain(4);
    // 4: ten push+pop pairs at count 1, pointers wrap
    drv(0, 0, 1, 8'h0F, 0);
    for (int i = 0; i < 10; i++) drv(0, 0, 1, W'(8'h10 + i), 1);
    drain(3);
    // 5: flush with a push at count 3
    for (int i = 0; i < 3; i++) drv(0, 0, 1, W'(8'h30 + i), 0);
    drv(0, 1, 1, 8'hEE, 0);
    idle(1);
    drain(2);
    // 6: reset with push and pop active at count 2
    drv(0, 0, 1, 8'h41, 0);
    drv(0, 0, 1, 8'h42, 0);
    drv(1, 0, 1, 8'h43, 1);
    idle(1);
    // random traffic with occasional flush
    for (int i = 0; i < 400; i++)
      drv(0, ($urandom_range(0, 29) == 0), $urandom_range(0, 1) == 1,
          W'($urandom), $urandom_range(0, 2) != 0);
    drain(6);
    idle(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
